// File: rtl/sms_reset_receiver_if.sv
// Console/backplane side of the machine-wide reset line: the raw RESET key in,
// the distributed reset pair, the release strobe and the key lamp out.
interface sms_reset_receiver_if;
    logic key_reset_n;
    logic reset_n_out;
    logic reset_p_out;
    logic reset_done;
    logic key_lamp;

    modport master (
        output key_reset_n,
        input  reset_n_out,
        input  reset_p_out,
        input  reset_done,
        input  key_lamp
    );

    modport slave (
        input  key_reset_n,
        output reset_n_out,
        output reset_p_out,
        output reset_done,
        output key_lamp
    );
endinterface

// File: rtl/sms_reset_receiver.sv
// Receiving end of -RESET: asserts asynchronously, releases synchronously after a
// hold time, and turns a debounced console key press into a full reset.
module sms_reset_receiver #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    sms_reset_receiver_if.slave bus
);
    localparam int MAX_CNT = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {HOLD, RUN, DEBOUNCE, KEY_HELD} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   reset_n_q;
    logic                   reset_done_q;
    logic                   key_lamp_q;
    logic [SYNC_STAGES-1:0] rst_chain;
    logic [SYNC_STAGES-1:0] key_chain;
    logic                   rst_sync;
    logic                   key_sync;

    assign cnt_inc  = cnt + CNT_W'(1);
    assign rst_sync = rst_chain[SYNC_STAGES-1];
    assign key_sync = key_chain[SYNC_STAGES-1];

    // Release synchronizer: assertion is immediate, release ripples through the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_chain <= '0;
        end else begin
            rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_chain <= '1;
        end else begin
            key_chain <= {key_chain[SYNC_STAGES-2:0], bus.key_reset_n};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HOLD;
            cnt          <= '0;
            reset_n_q    <= 1'b0;
            reset_done_q <= 1'b0;
            key_lamp_q   <= 1'b0;
        end else if (!rst_sync) begin
            state        <= HOLD;
            cnt          <= '0;
            reset_n_q    <= 1'b0;
            reset_done_q <= 1'b0;
            key_lamp_q   <= 1'b0;
        end else begin
            reset_done_q <= 1'b0;
            unique case (state)
                HOLD: begin
                    if (cnt_inc == HOLD_LAST) begin
                        state        <= RUN;
                        cnt          <= '0;
                        reset_n_q    <= 1'b1;
                        reset_done_q <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RUN: begin
                    if (!key_sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state      <= KEY_HELD;
                            cnt        <= '0;
                            reset_n_q  <= 1'b0;
                            key_lamp_q <= 1'b1;
                        end else begin
                            state <= DEBOUNCE;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (key_sync) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state      <= KEY_HELD;
                        cnt        <= '0;
                        reset_n_q  <= 1'b0;
                        key_lamp_q <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                KEY_HELD: begin
                    // A low sample means the key bounced; the release count starts over.
                    if (!key_sync) begin
                        cnt <= '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state      <= HOLD;
                        cnt        <= '0;
                        key_lamp_q <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state      <= HOLD;
                    cnt        <= '0;
                    reset_n_q  <= 1'b0;
                    key_lamp_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reset_n_out = reset_n_q;
    assign bus.reset_p_out = ~reset_n_q;
    assign bus.reset_done  = reset_done_q;
    assign bus.key_lamp    = key_lamp_q;
endmodule

// File: tb/tb_sms_reset_receiver.sv
// Directed bench for sms_reset_receiver: per-edge expected outputs are queued as
// stimulus is applied and drained one clock edge at a time.
module tb_sms_reset_receiver;
    logic clk;
    logic rst_n;

    sms_reset_receiver_if bus_if();

    sms_reset_receiver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic rn;
        logic done;
        logic lamp;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    int    edge_no = 0;
    string phase = "init";

    task automatic chk(input string tag, input logic obs, input logic req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s/%s edge=%0d observed=%b expected=%b", phase, tag, edge_no, obs, req);
        end
    endtask

    task automatic push(input int n, input logic rn, input logic done, input logic lamp);
        exp_t e;
        e.rn   = rn;
        e.done = done;
        e.lamp = lamp;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Power-on release: reset_n_out rises, with reset_done, on the 10th edge.
    task automatic push_power_on();
        push(9, 1'b0, 1'b0, 1'b0);
        push(1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            edge_no++;
            e = sb.pop_front();
            chk("reset_n_out", bus_if.reset_n_out, e.rn);
            chk("reset_p_out", bus_if.reset_p_out, ~e.rn);
            chk("reset_done",  bus_if.reset_done,  e.done);
            chk("key_lamp",    bus_if.key_lamp,    e.lamp);
        end
    endtask

    task automatic chk_async_reset();
        chk("async_n",    bus_if.reset_n_out, 1'b0);
        chk("async_p",    bus_if.reset_p_out, 1'b1);
        chk("async_done", bus_if.reset_done,  1'b0);
        chk("async_lamp", bus_if.key_lamp,    1'b0);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus_if.key_reset_n = 1'b1;
        #2;
        phase = "reset_state";
        chk_async_reset();

        phase = "power_on";
        push(5, 1'b0, 1'b0, 1'b0);
        drain();
        rst_n   = 1'b1;
        edge_no = 0;
        push_power_on();
        push(5, 1'b1, 1'b0, 1'b0);
        drain();

        phase = "async_assert";
        #3;
        rst_n = 1'b0;
        #1;
        chk_async_reset();
        push(1, 1'b0, 1'b0, 1'b0);
        drain();
        rst_n   = 1'b1;
        edge_no = 0;
        push_power_on();
        push(3, 1'b1, 1'b0, 1'b0);
        drain();

        phase = "clean_press";
        bus_if.key_reset_n = 1'b0;
        edge_no = 0;
        push(17, 1'b1, 1'b0, 1'b0);
        push(23, 1'b0, 1'b0, 1'b1);
        drain();
        phase = "clean_release";
        bus_if.key_reset_n = 1'b1;
        edge_no = 0;
        push(17, 1'b0, 1'b0, 1'b1);
        push(8, 1'b0, 1'b0, 1'b0);
        push(1, 1'b1, 1'b1, 1'b0);
        push(4, 1'b1, 1'b0, 1'b0);
        drain();

        phase = "bounce_reject";
        edge_no = 0;
        for (int r = 0; r < 5; r++) begin
            bus_if.key_reset_n = 1'b0;
            push(15, 1'b1, 1'b0, 1'b0);
            drain();
            bus_if.key_reset_n = 1'b1;
            push(1, 1'b1, 1'b0, 1'b0);
            drain();
        end
        push(20, 1'b1, 1'b0, 1'b0);
        drain();

        phase = "release_bounce";
        bus_if.key_reset_n = 1'b0;
        edge_no = 0;
        push(17, 1'b1, 1'b0, 1'b0);
        push(3, 1'b0, 1'b0, 1'b1);
        drain();
        bus_if.key_reset_n = 1'b1;
        push(10, 1'b0, 1'b0, 1'b1);
        drain();
        bus_if.key_reset_n = 1'b0;
        push(2, 1'b0, 1'b0, 1'b1);
        drain();
        bus_if.key_reset_n = 1'b1;
        edge_no = 0;
        push(17, 1'b0, 1'b0, 1'b1);
        push(8, 1'b0, 1'b0, 1'b0);
        push(1, 1'b1, 1'b1, 1'b0);
        push(4, 1'b1, 1'b0, 1'b0);
        drain();

        phase = "mid_hold_reset";
        rst_n = 1'b0;
        push(1, 1'b0, 1'b0, 1'b0);
        drain();
        rst_n   = 1'b1;
        edge_no = 0;
        push(7, 1'b0, 1'b0, 1'b0);
        drain();
        rst_n = 1'b0;
        push(2, 1'b0, 1'b0, 1'b0);
        drain();
        rst_n   = 1'b1;
        edge_no = 0;
        push_power_on();
        push(3, 1'b1, 1'b0, 1'b0);
        drain();

        phase = "key_through_power_on";
        rst_n              = 1'b0;
        bus_if.key_reset_n = 1'b0;
        push(2, 1'b0, 1'b0, 1'b0);
        drain();
        rst_n   = 1'b1;
        edge_no = 0;
        push_power_on();
        push(15, 1'b1, 1'b0, 1'b0);
        push(4, 1'b0, 1'b0, 1'b1);
        drain();

        phase = "async_in_key_held";
        #3;
        rst_n = 1'b0;
        #1;
        chk_async_reset();
        bus_if.key_reset_n = 1'b1;
        push(1, 1'b0, 1'b0, 1'b0);
        drain();
        rst_n   = 1'b1;
        edge_no = 0;
        push_power_on();
        push(3, 1'b1, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
